// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared constants and types for the CP0 exception controller: ExcCode values,
// MTC0 register addresses of the timer, the exception vector and the FSM state type.
package cp0_exc_ctrl_pkg;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    localparam logic [5:0] cp0addr_Count   = 6'd9;
    localparam logic [5:0] cp0addr_Compare = 6'd11;

    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        EXC_FLUSH  = 2'd1,
        ERET_FLUSH = 2'd2
    } exc_state_t;

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// Write-back stage to CP0 handshake: the committing instruction with its exception
// info, plus the pipeline redirect (flush) handshake.
interface cp0_exc_ctrl_if;
    logic        ws_valid;
    logic        ws_ex;
    logic [4:0]  ws_exccode;
    logic        ws_bd;
    logic        ws_eret;
    logic [31:0] ws_pc;
    logic [31:0] ws_badvaddr;
    logic        ws_ready;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic        flush_ack;

    modport master (
        output ws_valid, ws_ex, ws_exccode, ws_bd, ws_eret, ws_pc, ws_badvaddr, flush_ack,
        input  ws_ready, flush_req, flush_pc
    );

    modport slave (
        input  ws_valid, ws_ex, ws_exccode, ws_bd, ws_eret, ws_pc, ws_badvaddr, flush_ack,
        output ws_ready, flush_req, flush_pc
    );
endinterface

// File: rtl/cp0_exc_ctrl_timer.sv
// CP0 Count/Compare timer: Count advances every second clock, Equal pulses when it
// reaches Compare. Only instantiated when CP0_TIMER_EN is defined.
module cp0_timer
    import cp0_exc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mtc0_we,
    input  logic [5:0]  cp0_addr,
    input  logic [31:0] mtc0_data,
    output logic        equal,
    output logic [31:0] count_data,
    output logic [31:0] compare_data
);

    logic half;
    logic write_count;
    logic write_compare;

    assign write_count   = mtc0_we && (cp0_addr == cp0addr_Count);
    assign write_compare = mtc0_we && (cp0_addr == cp0addr_Compare);

    // Equal looks at the value Count is about to take, so it rises together with the match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half         <= 1'b0;
            count_data   <= 32'd0;
            compare_data <= 32'd0;
            equal        <= 1'b0;
        end else begin
            if (write_count) begin
                count_data <= mtc0_data;
                half       <= 1'b0;
            end else begin
                half <= ~half;
                if (half) begin
                    count_data <= count_data + 32'd1;
                end
            end
            if (write_compare) begin
                compare_data <= mtc0_data;
            end
            equal <= half && !write_count && !write_compare
                     && ((count_data + 32'd1) == compare_data);
        end
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/ERET commit controller with pipeline flush handshake.
// Optional Count/Compare timer is built in when CP0_TIMER_EN is defined.
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    cp0_exc_ctrl_if.slave ws,
    input  logic         status_ie,
    input  logic         status_exl,
    input  logic [7:0]   status_im,
    input  logic [7:0]   cause_ip,
    input  logic [31:0]  epc,
    input  logic         mtc0_we,
    input  logic [5:0]   cp0_addr,
    input  logic [31:0]  mtc0_data,
    output logic         exception,
    output logic [4:0]   exc_code,
    output logic         bd,
    output logic         eret_flush,
    output logic [31:0]  exc_pc,
    output logic [31:0]  exc_badvaddr,
    output logic         int_pending,
    output logic         equal,
    output logic [31:0]  count_data,
    output logic [31:0]  compare_data
);

    exc_state_t state;
    exc_state_t next_state;
    logic       take_exc;
    logic       take_eret;

    assign int_pending = status_ie && !status_exl && (|(cause_ip & status_im));

    // Interrupts outrank a synchronous exception, which outranks eret.
    assign take_exc  = (state == IDLE) && ws.ws_valid && (int_pending || ws.ws_ex);
    assign take_eret = (state == IDLE) && ws.ws_valid && !int_pending && !ws.ws_ex
                       && ws.ws_eret;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (take_exc) begin
                    next_state = EXC_FLUSH;
                end else if (take_eret) begin
                    next_state = ERET_FLUSH;
                end
            end
            EXC_FLUSH, ERET_FLUSH: begin
                if (ws.flush_ack) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ws.ws_ready  = (state == IDLE);
        ws.flush_req = (state != IDLE);
    end

    // Commit pulses and payload; flush_pc is captured on entry so EPC may change underneath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exception    <= 1'b0;
            eret_flush   <= 1'b0;
            exc_code     <= 5'd0;
            bd           <= 1'b0;
            exc_pc       <= 32'd0;
            exc_badvaddr <= 32'd0;
            ws.flush_pc  <= 32'd0;
        end else begin
            exception  <= take_exc;
            eret_flush <= take_eret;
            if (take_exc) begin
                exc_code     <= int_pending ? EXC_INT : ws.ws_exccode;
                bd           <= ws.ws_bd;
                exc_pc       <= ws.ws_pc;
                exc_badvaddr <= ws.ws_badvaddr;
                ws.flush_pc  <= EXC_VECTOR;
            end else if (take_eret) begin
                ws.flush_pc  <= epc;
            end
        end
    end

`ifdef CP0_TIMER_EN
    cp0_timer u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .mtc0_we      (mtc0_we),
        .cp0_addr     (cp0_addr),
        .mtc0_data    (mtc0_data),
        .equal        (equal),
        .count_data   (count_data),
        .compare_data (compare_data)
    );
`else
    logic timer_unused;
    assign timer_unused = &{1'b0, mtc0_we, cp0_addr, mtc0_data};
    assign equal        = 1'b0;
    assign count_data   = 32'd0;
    assign compare_data = 32'd0;
`endif

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Randomized and directed bench for cp0_exc_ctrl against a cycle-level reference model.
// Timer checks follow CP0_TIMER_EN the same way the design does.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        status_ie = 1'b0;
    logic        status_exl = 1'b0;
    logic [7:0]  status_im = 8'h00;
    logic [7:0]  cause_ip = 8'h00;
    logic [31:0] epc = 32'd0;
    logic        mtc0_we = 1'b0;
    logic [5:0]  cp0_addr = 6'd0;
    logic [31:0] mtc0_data = 32'd0;
    logic        exception, bd, eret_flush, int_pending, equal;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc, exc_badvaddr, count_data, compare_data;

    int total = 0;
    int bad = 0;

    // Reference model state: whether a redirect is outstanding and the last commit.
    bit          m_busy;
    logic [31:0] m_flush_pc;
    bit          m_exc, m_eret;
    logic [4:0]  m_code;
    bit          m_bd;
    logic [31:0] m_pc, m_bad;
    logic [31:0] m_count_base, m_cmp;
    int unsigned m_cycles;
    bit          m_equal;

    cp0_exc_ctrl_if ws_bus ();

    cp0_exc_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ws           (ws_bus),
        .status_ie    (status_ie),
        .status_exl   (status_exl),
        .status_im    (status_im),
        .cause_ip     (cause_ip),
        .epc          (epc),
        .mtc0_we      (mtc0_we),
        .cp0_addr     (cp0_addr),
        .mtc0_data    (mtc0_data),
        .exception    (exception),
        .exc_code     (exc_code),
        .bd           (bd),
        .eret_flush   (eret_flush),
        .exc_pc       (exc_pc),
        .exc_badvaddr (exc_badvaddr),
        .int_pending  (int_pending),
        .equal        (equal),
        .count_data   (count_data),
        .compare_data (compare_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] modelCount();
        return m_count_base + 32'(m_cycles / 2);
    endfunction

    task automatic modelReset();
        m_busy = 0; m_flush_pc = 32'd0; m_exc = 0; m_eret = 0;
        m_code = 5'd0; m_bd = 0; m_pc = 32'd0; m_bad = 32'd0;
        m_count_base = 32'd0; m_cmp = 32'd0; m_cycles = 0; m_equal = 0;
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        #2;
        modelReset();
        checkOutput("rst_flush_req", 32'(ws_bus.flush_req), 32'd0);
        checkOutput("rst_exception", 32'(exception), 32'd0);
        checkOutput("rst_eret_flush", 32'(eret_flush), 32'd0);
        checkOutput("rst_ws_ready", 32'(ws_bus.ws_ready), 32'd1);
        checkOutput("rst_bd", 32'(bd), 32'd0);
        checkOutput("rst_exc_code", 32'(exc_code), 32'd0);
        checkOutput("rst_exc_pc", exc_pc, 32'd0);
        checkOutput("rst_badvaddr", exc_badvaddr, 32'd0);
        checkOutput("rst_flush_pc", ws_bus.flush_pc, 32'd0);
        checkOutput("rst_equal", 32'(equal), 32'd0);
        checkOutput("rst_count", count_data, 32'd0);
        checkOutput("rst_compare", compare_data, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic runCycle();
        bit int_p, take_e, take_r, wc, wcmp;
        #1;
        int_p = status_ie && !status_exl && ((cause_ip & status_im) != 8'h00);
        checkOutput("int_pending", 32'(int_pending), 32'(int_p));
        checkOutput("ws_ready", 32'(ws_bus.ws_ready), 32'(!m_busy));
        checkOutput("flush_req", 32'(ws_bus.flush_req), 32'(m_busy));
        if (m_busy) checkOutput("flush_pc", ws_bus.flush_pc, m_flush_pc);

        take_e = !m_busy && ws_bus.ws_valid && (int_p || ws_bus.ws_ex);
        take_r = !m_busy && ws_bus.ws_valid && !take_e && ws_bus.ws_eret;
        m_exc = take_e;
        m_eret = take_r;
        if (take_e) begin
            m_code = int_p ? 5'h00 : ws_bus.ws_exccode;
            m_bd = ws_bus.ws_bd;
            m_pc = ws_bus.ws_pc;
            m_bad = ws_bus.ws_badvaddr;
            m_busy = 1;
            m_flush_pc = 32'hBFC0_0380;
        end else if (take_r) begin
            m_busy = 1;
            m_flush_pc = epc;
        end else if (m_busy && ws_bus.flush_ack) begin
            m_busy = 0;
        end

        wc = mtc0_we && (cp0_addr == 6'd9);
        wcmp = mtc0_we && (cp0_addr == 6'd11);
        if (wc) begin
            m_count_base = mtc0_data;
            m_cycles = 0;
        end else begin
            m_cycles++;
        end
        m_equal = !wc && !wcmp && (m_cycles != 0) && (m_cycles % 2 == 0) && (modelCount() == m_cmp);
        if (wcmp) m_cmp = mtc0_data;

        @(posedge clk);
        #1;
        checkOutput("exception", 32'(exception), 32'(m_exc));
        checkOutput("eret_flush", 32'(eret_flush), 32'(m_eret));
        checkOutput("exc_code", 32'(exc_code), 32'(m_code));
        checkOutput("bd", 32'(bd), 32'(m_bd));
        checkOutput("exc_pc", exc_pc, m_pc);
        checkOutput("exc_badvaddr", exc_badvaddr, m_bad);
`ifdef CP0_TIMER_EN
        checkOutput("equal", 32'(equal), 32'(m_equal));
        checkOutput("count_data", count_data, modelCount());
        checkOutput("compare_data", compare_data, m_cmp);
`else
        checkOutput("equal_off", 32'(equal), 32'd0);
        checkOutput("count_off", count_data, 32'd0);
        checkOutput("compare_off", compare_data, 32'd0);
`endif
    endtask

    task automatic applyStimulus(input bit valid, input bit ex, input logic [4:0] code, input bit bdi,
                                 input bit eret, input logic [31:0] pc, input logic [31:0] bad_va,
                                 input bit ack);
        ws_bus.ws_valid = valid;
        ws_bus.ws_ex = ex;
        ws_bus.ws_exccode = code;
        ws_bus.ws_bd = bdi;
        ws_bus.ws_eret = eret;
        ws_bus.ws_pc = pc;
        ws_bus.ws_badvaddr = bad_va;
        ws_bus.flush_ack = ack;
        runCycle();
    endtask

    task automatic idleCycles(input int n, input bit ack);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 5'd0, 0, 0, 32'd0, 32'd0, ack);
    endtask

    initial begin
        int pulse_at, pulses;
        logic [5:0] addr_pick [3];
        addr_pick[0] = 6'd9; addr_pick[1] = 6'd11; addr_pick[2] = 6'd12;
        ws_bus.ws_valid = 0; ws_bus.ws_ex = 0; ws_bus.ws_exccode = 0; ws_bus.ws_bd = 0;
        ws_bus.ws_eret = 0; ws_bus.ws_pc = 0; ws_bus.ws_badvaddr = 0; ws_bus.flush_ack = 0;
        resetDut();

        $display("[TB] syscall commit and flush");
        applyStimulus(1, 1, 5'h08, 1, 0, 32'h8000_1000, 32'h0000_0044, 0);
        checkOutput("sys_exception", 32'(exception), 32'd1);
        checkOutput("sys_code", 32'(exc_code), 32'h08);
        idleCycles(3, 0);
        applyStimulus(0, 0, 5'd0, 0, 0, 32'd0, 32'd0, 1);
        checkOutput("sys_ready_after_ack", 32'(ws_bus.ws_ready), 32'd1);
        idleCycles(1, 1);

        $display("[TB] interrupt outranks exception");
        status_ie = 1; status_exl = 0; status_im = 8'h80; cause_ip = 8'h80;
        applyStimulus(1, 1, 5'h04, 0, 1, 32'h8000_2000, 32'h1234_5678, 0);
        checkOutput("int_code", 32'(exc_code), 32'h00);
        checkOutput("int_no_eret", 32'(eret_flush), 32'd0);
        applyStimulus(0, 0, 5'd0, 0, 0, 32'd0, 32'd0, 1);

        $display("[TB] masked interrupt");
        status_exl = 1;
        applyStimulus(1, 0, 5'h04, 0, 0, 32'h8000_3000, 32'd0, 0);
        checkOutput("masked_exception", 32'(exception), 32'd0);
        checkOutput("masked_int_pending", 32'(int_pending), 32'd0);

        $display("[TB] eret with delayed ack");
        status_ie = 0; status_exl = 0; epc = 32'h8000_2004;
        applyStimulus(1, 0, 5'd0, 0, 1, 32'h8000_4000, 32'd0, 0);
        checkOutput("eret_pulse", 32'(eret_flush), 32'd1);
        epc = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) applyStimulus(1, 1, 5'h0c, 0, 1, 32'h8000_5000, 32'd0, 0);
        checkOutput("eret_flush_pc_held", ws_bus.flush_pc, 32'h8000_2004);
        applyStimulus(0, 0, 5'd0, 0, 0, 32'd0, 32'd0, 1);

        $display("[TB] flush_ack ignored in idle, no action without valid");
        status_ie = 1; status_im = 8'h01; cause_ip = 8'h01;
        idleCycles(2, 1);
        status_ie = 0;

        $display("[TB] reset during exception flush");
        applyStimulus(1, 1, 5'h0a, 0, 0, 32'h8000_6000, 32'd0, 0);
        resetDut();
        idleCycles(2, 0);
        checkOutput("post_rst_exception", 32'(exception), 32'd0);

        $display("[TB] timer match and suppressed match");
        mtc0_we = 1; cp0_addr = 6'd11; mtc0_data = 32'd3;
        idleCycles(1, 0);
        cp0_addr = 6'd9; mtc0_data = 32'd0;
        idleCycles(1, 0);
        mtc0_we = 0;
        pulse_at = 0; pulses = 0;
        for (int i = 1; i <= 10; i++) begin
            idleCycles(1, 0);
            if (equal) begin pulses++; pulse_at = i; end
        end
`ifdef CP0_TIMER_EN
        checkOutput("eq_pulses", 32'(pulses), 32'd1);
        checkOutput("eq_delay", 32'(pulse_at), 32'd6);
`else
        checkOutput("eq_pulses_off", 32'(pulses), 32'd0);
`endif
        mtc0_we = 1; cp0_addr = 6'd9; mtc0_data = 32'd0;
        idleCycles(1, 0);
        mtc0_we = 0;
        idleCycles(5, 0);
        mtc0_we = 1; cp0_addr = 6'd11; mtc0_data = 32'd3;
        idleCycles(1, 0);
        checkOutput("eq_suppressed", 32'(equal), 32'd0);
        mtc0_we = 0;
        idleCycles(4, 0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            status_ie = 1'($urandom_range(0, 1));
            status_exl = ($urandom_range(0, 3) == 0);
            status_im = 8'($urandom);
            cause_ip = ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            epc = $urandom;
            mtc0_we = ($urandom_range(0, 4) == 0);
            cp0_addr = addr_pick[$urandom_range(0, 2)];
            mtc0_data = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 40));
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 6) == 0, 5'($urandom),
                          1'($urandom_range(0, 1)), $urandom_range(0, 6) == 0, $urandom, $urandom,
                          $urandom_range(0, 9) < 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cp0_exc_ctrl.md
CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on posedge.
REQ-002 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have inputs ws_valid (1), ws_ex (1), ws_exccode (5), ws_bd (1), ws_eret (1), ws_pc (32), ws_badvaddr (32): the write-back instruction and its exception info.
REQ-004 SHALL have inputs status_ie (1), status_exl (1), status_im (8), cause_ip (8), epc (32): current CP0 Status, Cause and EPC values.
REQ-005 SHALL have inputs mtc0_we (1), cp0_addr (6), mtc0_data (32): the MTC0 write port.
REQ-006 SHALL have input flush_ack (1): the pipeline accepts the redirect.
REQ-007 SHALL have outputs exception (1), exc_code (5), bd (1), eret_flush (1), exc_pc (32), exc_badvaddr (32): the commit pulse and its payload to the CP0 registers.
REQ-008 SHALL have outputs flush_req (1), flush_pc (32), ws_ready (1), int_pending (1), equal (1), count_data (32), compare_data (32).

Function
REQ-009 SHALL set int_pending = status_ie & ~status_exl & |(cause_ip & status_im), combinationally.
REQ-010 SHALL use an FSM with states IDLE, EXC_FLUSH and ERET_FLUSH; ws_ready = (state==IDLE).
REQ-011 In IDLE with ws_valid=1, SHALL select by priority: int_pending (exc_code 5'h00), then ws_ex (exc_code=ws_exccode), then ws_eret.
REQ-012 On a selected interrupt or exception, SHALL pulse exception=1 for exactly one cycle on the next edge, latching exc_code, bd=ws_bd, exc_pc=ws_pc and exc_badvaddr=ws_badvaddr, then enter EXC_FLUSH.
REQ-013 On a selected eret, SHALL pulse eret_flush=1 for one cycle on the next edge and enter ERET_FLUSH.
REQ-014 SHALL never assert exception and eret_flush in the same cycle; ws_ex together with ws_eret yields exception only.
REQ-015 In EXC_FLUSH, SHALL drive flush_req=1 with flush_pc=32'hBFC0_0380.
REQ-016 In ERET_FLUSH, SHALL drive flush_req=1 with flush_pc=epc, sampled on state entry.
REQ-017 SHALL hold flush_req and flush_pc stable until the cycle flush_ack=1, then return to IDLE on the next edge; flush_ack in IDLE SHALL be ignored.
REQ-018 Outside IDLE, SHALL ignore ws_* inputs and interrupts; no exception or eret_flush pulse.
REQ-019 With ws_valid=0, SHALL take no action, even when int_pending=1.

Reset
REQ-020 During rst_n=0: state=IDLE; exception, eret_flush, flush_req, bd, equal = 0; exc_code, exc_pc, exc_badvaddr, flush_pc, count_data, compare_data = 0.
REQ-021 Reset asserted mid-flush SHALL abort to IDLE immediately, with no completion pulse after release.

Configuration
REQ-022 Macro CP0_TIMER_EN defined: SHALL include the Count/Compare timer.
  - count_data increments by 1 every second clock, wrapping 32'hFFFF_FFFF to 0.
  - MTC0 to `cp0addr_Count` loads count_data and clears the half-cycle toggle.
  - MTC0 to `cp0addr_Compare` loads compare_data.
  - equal pulses for one cycle when count_data==compare_data on the increment edge.
  - A same-cycle MTC0 write takes priority over increment and suppresses equal.
REQ-023 Macro CP0_TIMER_EN undefined: SHALL tie equal, count_data and compare_data to 0 and ignore MTC0 writes.

Structure
REQ-024 SHALL place ExcCode values (Int=5'h00, AdEL=5'h04, Sys=5'h08, ...), cp0addr_Count, cp0addr_Compare and the exception vector constant in defines.vh.
REQ-025 SHALL implement the timer as sub-module cp0_timer, instantiated under CP0_TIMER_EN.

Verification
REQ-026 Syscall: ws_valid=1, ws_ex=1, ws_exccode=5'h08, ws_pc=32'h8000_1000, ws_bd=1 -> next cycle exception=1, exc_code=8, bd=1, exc_pc=32'h8000_1000; flush_req=1, flush_pc=32'hBFC0_0380 until flush_ack, then ws_ready=1.
REQ-027 Interrupt priority: status_ie=1, status_exl=0, status_im=8'h80, cause_ip=8'h80, ws_ex=1 with code 4 -> exc_code=0.
REQ-028 Masked interrupt: same as REQ-027 with status_exl=1 and ws_ex=0 -> no exception, int_pending=0.
REQ-029 Eret: epc=32'h8000_2004, ws_eret=1 -> eret_flush one cycle, flush_pc=32'h8000_2004; flush_ack delayed 5 cycles -> flush_req held for 5 cycles, no new pulse.
REQ-030 Timer (CP0_TIMER_EN defined): write compare=3, count=0 -> equal pulses once, 6 cycles after the count write; writing compare in the match cycle -> no pulse.
REQ-031 Reset mid-flush: rst_n low during EXC_FLUSH -> flush_req=0 immediately; state=IDLE after release.
